// File: rtl/cam_dvp_capture.sv
// DVP pixel-capture front end: synchronises the camera bus into clk, assembles pixels,
// crops/decimates the window and writes {sof, pixel} to a FIFO with overflow accounting.
module cam_dvp_capture #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int X0            = 0,
  parameter int Y0            = 0,
  parameter int WIN_W         = 640,
  parameter int WIN_H         = 480,
  parameter int DECIM         = 1,
  parameter int DROP_ON_OVF   = 1,
  parameter int CNT_W         = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            single_shot,
  input  logic                            clear_stats,
  input  logic                            cmos_pclk,
  input  logic                            cmos_href,
  input  logic                            cmos_vsync,
  input  logic [DATA_W-1:0]               cmos_db,
  input  logic                            fifo_full,
  output logic                            wr_en,
  output logic [DATA_W*BYTES_PER_PIX:0]   wr_data,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            overflow,
  output logic [CNT_W-1:0]                drop_cnt
);

  localparam int PIX_W = DATA_W * BYTES_PER_PIX;
  localparam int PH_W  = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
  localparam int DPH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int XW    = $clog2(X0 + WIN_W + 1) + 1;
  localparam int YW    = $clog2(Y0 + WIN_H + 1) + 1;

  localparam logic [PH_W-1:0]       PH_LAST  = PH_W'(BYTES_PER_PIX - 1);
  localparam logic [DPH_W-1:0]      DPH_LAST = DPH_W'(DECIM - 1);
  localparam logic signed [XW-1:0]  X_START  = XW'(-X0);
  localparam logic signed [XW-1:0]  X_END    = XW'(WIN_W);
  localparam logic signed [YW-1:0]  Y_START  = YW'(-Y0);
  localparam logic signed [YW-1:0]  Y_END    = YW'(WIN_H);
  localparam logic [CNT_W-1:0]      CNT_MAX  = '1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARM    = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_DROP   = 2'd3;

  logic              pclk_s1, pclk_s2, pclk_s3;
  logic              href_s1, href_s2, href_s3;
  logic              vsync_s1, vsync_s2, vsync_s3;
  logic [DATA_W-1:0] db_s1, db_s2;

  // NOTE: flops use non-blocking assignments so each stage samples the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {pclk_s3, pclk_s2, pclk_s1}    <= '0;
      {href_s3, href_s2, href_s1}    <= '0;
      {vsync_s3, vsync_s2, vsync_s1} <= '0;
      db_s1 <= '0;
      db_s2 <= '0;
    end else begin
      {pclk_s3, pclk_s2, pclk_s1}    <= {pclk_s2, pclk_s1, cmos_pclk};
      {href_s3, href_s2, href_s1}    <= {href_s2, href_s1, cmos_href};
      {vsync_s3, vsync_s2, vsync_s1} <= {vsync_s2, vsync_s1, cmos_vsync};
      db_s1 <= cmos_db;
      db_s2 <= db_s1;
    end
  end

  logic pclk_rise, href_rise, href_fall, vsync_rise, vsync_fall;
  assign pclk_rise  =  pclk_s2 & ~pclk_s3;
  assign href_rise  =  href_s2 & ~href_s3;
  assign href_fall  = ~href_s2 &  href_s3;
  assign vsync_rise =  vsync_s2 & ~vsync_s3;
  assign vsync_fall = ~vsync_s2 &  vsync_s3;

  logic [PH_W-1:0]        byte_ph, ph_eff;
  logic [PIX_W-1:0]       pix_reg, pix_next;
  logic signed [XW-1:0]   x_pos;
  logic signed [YW-1:0]   y_pos;
  logic [DPH_W-1:0]       phase_x, phase_y;
  logic                   byte_take, pix_done, in_win;

  // A byte arriving together with href_rise starts a fresh pixel.
  assign ph_eff    = href_rise ? '0 : byte_ph;
  assign byte_take = pclk_rise & href_s2;
  assign pix_done  = byte_take & (ph_eff == PH_LAST);
  assign pix_next  = (pix_reg << DATA_W) | PIX_W'(db_s2);

  // Positions are kept relative to the window origin, so "inside" is a sign test.
  assign in_win = !x_pos[XW-1] && (x_pos < X_END) && !y_pos[YW-1] && (y_pos < Y_END) &&
                  (phase_x == '0) && (phase_y == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_ph <= '0;
      pix_reg <= '0;
      x_pos   <= '0;
      y_pos   <= '0;
      phase_x <= '0;
      phase_y <= '0;
    end else begin
      if (byte_take) begin
        pix_reg <= pix_next;
        byte_ph <= pix_done ? '0 : ph_eff + 1'b1;
      end else if (href_rise || href_fall) begin
        byte_ph <= '0;
      end

      if (vsync_fall || href_fall) begin
        x_pos   <= X_START;
        phase_x <= '0;
      end else if (pix_done) begin
        if (x_pos != X_END) x_pos <= x_pos + 1'b1;
        if (!x_pos[XW-1]) phase_x <= (phase_x == DPH_LAST) ? '0 : phase_x + 1'b1;
      end

      if (vsync_fall) begin
        y_pos   <= Y_START;
        phase_y <= '0;
      end else if (href_fall) begin
        if (y_pos != Y_END) y_pos <= y_pos + 1'b1;
        if (!y_pos[YW-1]) phase_y <= (phase_y == DPH_LAST) ? '0 : phase_y + 1'b1;
      end
    end
  end

  logic [1:0] state;
  logic       ss_latched, shot_done, sof_pend;
  logic       keep, ovf_evt;

  assign keep    = (state == S_ACTIVE) & pix_done & in_win;
  assign ovf_evt = keep & fifo_full;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ss_latched <= 1'b0;
      shot_done  <= 1'b0;
      sof_pend   <= 1'b0;
      wr_en      <= 1'b0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      // A finished single shot keeps the block idle until enable is dropped.
      if (!enable) shot_done <= 1'b0;

      case (state)
        S_IDLE: if (enable && !shot_done) state <= S_ARM;
        S_ARM: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (vsync_fall) begin
            state      <= S_ACTIVE;
            ss_latched <= single_shot;
            sof_pend   <= 1'b1;
          end
        end
        S_ACTIVE, S_DROP: begin
          if (vsync_rise) begin
            frame_done <= (state == S_ACTIVE);
            state      <= (ss_latched || !enable) ? S_IDLE : S_ARM;
            if (ss_latched && enable) shot_done <= 1'b1;
          end else if (vsync_fall && state == S_ACTIVE) begin
            sof_pend <= 1'b1;
          end else if (ovf_evt && DROP_ON_OVF != 0) begin
            state <= S_DROP;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (keep && !fifo_full) begin
        wr_en    <= 1'b1;
        wr_data  <= {sof_pend, pix_next};
        sof_pend <= 1'b0;
      end

      if (ovf_evt) begin
        overflow <= 1'b1;
        if (clear_stats)              drop_cnt <= CNT_W'(1);
        else if (drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
      end else if (clear_stats) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

endmodule
